// File: rtl/serial_dft_sequencer_if.sv
// Signal bundle between the DFT frame sequencer and its sample source, accumulator core and result sink.
// The master modport is the sequencer's view; slave is the view of everything around it.
`timescale 1ns/1ps
interface serial_dft_sequencer_if #(
    parameter int X_WIDTH = 16,
    parameter int S_WIDTH = 32,
    parameter int BW      = 2
);
    logic                      s_valid;
    logic                      s_ready;
    logic signed [X_WIDTH-1:0] s_x1;
    logic signed [X_WIDTH-1:0] s_x2;

    logic                      core_valid;
    logic signed [X_WIDTH-1:0] core_x1;
    logic signed [X_WIDTH-1:0] core_x2;
    logic        [BW-1:0]      core_bin;
    logic signed [S_WIDTH-1:0] core_re1;
    logic signed [S_WIDTH-1:0] core_im1;
    logic signed [S_WIDTH-1:0] core_re2;
    logic signed [S_WIDTH-1:0] core_im2;
    logic                      core_valid_o;

    logic                      m_valid;
    logic                      m_ready;
    logic        [BW-1:0]      m_bin;
    logic signed [S_WIDTH-1:0] m_re1;
    logic signed [S_WIDTH-1:0] m_im1;
    logic signed [S_WIDTH-1:0] m_re2;
    logic signed [S_WIDTH-1:0] m_im2;
    logic                      m_last;
    logic                      busy;

    modport master (
        input  s_valid, s_x1, s_x2,
        input  core_re1, core_im1, core_re2, core_im2, core_valid_o,
        input  m_ready,
        output s_ready,
        output core_valid, core_x1, core_x2, core_bin,
        output m_valid, m_bin, m_re1, m_im1, m_re2, m_im2, m_last, busy
    );

    modport slave (
        output s_valid, s_x1, s_x2,
        output core_re1, core_im1, core_re2, core_im2, core_valid_o,
        output m_ready,
        input  s_ready,
        input  core_valid, core_x1, core_x2, core_bin,
        input  m_valid, m_bin, m_re1, m_im1, m_re2, m_im2, m_last, busy
    );
endinterface

// File: rtl/serial_dft_sequencer.sv
// Frame controller for the two-channel serial DFT core: captures one frame, replays it once per bin,
// and hands each bin's four accumulated results downstream.
`timescale 1ns/1ps
module serial_dft_sequencer #(
    parameter int X_WIDTH      = 16,
    parameter int S_WIDTH      = 32,
    parameter int FRAME_LENGTH = 3,
    parameter int NUM_BINS     = 3
) (
    input  logic                  clk,
    input  logic                  arstn,
    serial_dft_sequencer_if.master bus
);
    localparam int BW = (NUM_BINS > 1) ? $clog2(NUM_BINS) : 1;
    localparam int PW = $clog2(FRAME_LENGTH);
    localparam logic [PW-1:0] PTR_LAST = PW'(FRAME_LENGTH - 1);
    localparam logic [BW-1:0] BIN_LAST = BW'(NUM_BINS - 1);

    typedef enum logic [1:0] {
        ST_FILL = 2'd0,
        ST_RUN  = 2'd1,
        ST_WAIT = 2'd2,
        ST_OUT  = 2'd3
    } state_t;

    state_t                    state_q, state_d;
    logic        [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic        [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic        [BW-1:0]      bin_q, bin_d;
    logic                      m_valid_q, m_valid_d;
    logic                      m_last_q, m_last_d;
    logic        [BW-1:0]      m_bin_q, m_bin_d;
    logic signed [S_WIDTH-1:0] m_re1_q, m_re1_d;
    logic signed [S_WIDTH-1:0] m_im1_q, m_im1_d;
    logic signed [S_WIDTH-1:0] m_re2_q, m_re2_d;
    logic signed [S_WIDTH-1:0] m_im2_q, m_im2_d;
    logic                      buf_we_s;

    logic signed [X_WIDTH-1:0] buf1_q [FRAME_LENGTH];
    logic signed [X_WIDTH-1:0] buf2_q [FRAME_LENGTH];

    // Control and result registers.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state_q   <= ST_FILL;
            wr_ptr_q  <= {PW{1'b0}};
            rd_ptr_q  <= {PW{1'b0}};
            bin_q     <= {BW{1'b0}};
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            m_bin_q   <= {BW{1'b0}};
            m_re1_q   <= {S_WIDTH{1'b0}};
            m_im1_q   <= {S_WIDTH{1'b0}};
            m_re2_q   <= {S_WIDTH{1'b0}};
            m_im2_q   <= {S_WIDTH{1'b0}};
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            bin_q     <= bin_d;
            m_valid_q <= m_valid_d;
            m_last_q  <= m_last_d;
            m_bin_q   <= m_bin_d;
            m_re1_q   <= m_re1_d;
            m_im1_q   <= m_im1_d;
            m_re2_q   <= m_re2_d;
            m_im2_q   <= m_im2_d;
        end
    end

    // Sample buffers: contents survive reset, but nothing is written while reset is held.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
        end else if (buf_we_s) begin
            buf1_q[wr_ptr_q] <= bus.s_x1;
            buf2_q[wr_ptr_q] <= bus.s_x2;
        end
    end

    // Next-state logic for fill / replay / result handoff.
    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        bin_d     = bin_q;
        m_valid_d = m_valid_q;
        m_last_d  = m_last_q;
        m_bin_d   = m_bin_q;
        m_re1_d   = m_re1_q;
        m_im1_d   = m_im1_q;
        m_re2_d   = m_re2_q;
        m_im2_d   = m_im2_q;
        buf_we_s  = 1'b0;
        case (state_q)
            ST_FILL: begin
                if (bus.s_valid) begin
                    buf_we_s = 1'b1;
                    if (wr_ptr_q == PTR_LAST) begin
                        wr_ptr_d = {PW{1'b0}};
                        rd_ptr_d = {PW{1'b0}};
                        bin_d    = {BW{1'b0}};
                        state_d  = ST_RUN;
                    end else begin
                        wr_ptr_d = wr_ptr_q + PW'(1);
                    end
                end else begin
                    buf_we_s = 1'b0;
                end
            end
            ST_RUN: begin
                // Always a full burst with no stall, so the core's sample counter wraps to 0 each pass.
                if (rd_ptr_q == PTR_LAST) begin
                    rd_ptr_d = {PW{1'b0}};
                    state_d  = ST_WAIT;
                end else begin
                    rd_ptr_d = rd_ptr_q + PW'(1);
                end
            end
            ST_WAIT: begin
                if (bus.core_valid_o) begin
                    m_re1_d   = bus.core_re1;
                    m_im1_d   = bus.core_im1;
                    m_re2_d   = bus.core_re2;
                    m_im2_d   = bus.core_im2;
                    m_bin_d   = bin_q;
                    m_last_d  = (bin_q == BIN_LAST);
                    m_valid_d = 1'b1;
                    state_d   = ST_OUT;
                end else begin
                    state_d   = ST_WAIT;
                end
            end
            ST_OUT: begin
                if (bus.m_ready) begin
                    m_valid_d = 1'b0;
                    m_last_d  = 1'b0;
                    if (bin_q == BIN_LAST) begin
                        state_d = ST_FILL;
                    end else begin
                        bin_d   = bin_q + BW'(1);
                        state_d = ST_RUN;
                    end
                end else begin
                    state_d = ST_OUT;
                end
            end
            default: begin
                state_d = ST_FILL;
            end
        endcase
    end

    assign bus.s_ready    = (state_q == ST_FILL);
    assign bus.busy       = (state_q != ST_FILL);
    assign bus.core_valid = (state_q == ST_RUN);
    assign bus.core_x1    = buf1_q[rd_ptr_q];
    assign bus.core_x2    = buf2_q[rd_ptr_q];
    assign bus.core_bin   = bin_q;
    assign bus.m_valid    = m_valid_q;
    assign bus.m_last     = m_last_q;
    assign bus.m_bin      = m_bin_q;
    assign bus.m_re1      = m_re1_q;
    assign bus.m_im1      = m_im1_q;
    assign bus.m_re2      = m_re2_q;
    assign bus.m_im2      = m_im2_q;
endmodule

// File: tb/tb_serial_dft_sequencer.sv
// Bench for serial_dft_sequencer: a behavioural DFT core plus table-driven and randomized frames
// checked against expected bin results computed directly from the twiddle rows.
`timescale 1ns/1ps
module tb_serial_dft_sequencer;
    localparam int FL = 3;
    localparam int NB = 3;

    logic clk   = 1'b0;
    logic arstn = 1'b1;
    int   cyc   = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    serial_dft_sequencer_if #(.X_WIDTH(16), .S_WIDTH(32), .BW(2)) bus ();

    serial_dft_sequencer #(
        .X_WIDTH(16), .S_WIDTH(32), .FRAME_LENGTH(FL), .NUM_BINS(NB)
    ) dut (
        .clk  (clk),
        .arstn(arstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    int W_RE [NB][FL] = '{'{1, 1, 1}, '{1, -1, 0}, '{0, 1, -1}};

    task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Behavioural accumulator core: one result set per FL accepted samples.
    int          c_n = 0;
    int          a_re1 = 0, a_re2 = 0;
    int          c_re1 = 0, c_re2 = 0;
    logic        c_vo = 1'b0;

    function automatic int wgt(input int k, input int n);
        if (k < NB && n < FL) return W_RE[k][n];
        return 0;
    endfunction

    always @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            c_n   <= 0;
            a_re1 <= 0;
            a_re2 <= 0;
            c_vo  <= 1'b0;
        end else begin
            c_vo <= 1'b0;
            if (bus.core_valid) begin
                if (c_n == FL - 1) begin
                    c_re1 <= a_re1 + wgt(int'(bus.core_bin), c_n) * int'(bus.core_x1);
                    c_re2 <= a_re2 + wgt(int'(bus.core_bin), c_n) * int'(bus.core_x2);
                    c_vo  <= 1'b1;
                    a_re1 <= 0;
                    a_re2 <= 0;
                    c_n   <= 0;
                end else begin
                    a_re1 <= a_re1 + wgt(int'(bus.core_bin), c_n) * int'(bus.core_x1);
                    a_re2 <= a_re2 + wgt(int'(bus.core_bin), c_n) * int'(bus.core_x2);
                    c_n   <= c_n + 1;
                end
            end
        end
    end

    assign bus.core_re1     = c_re1;
    assign bus.core_re2     = c_re2;
    assign bus.core_im1     = 32'sd0;
    assign bus.core_im2     = 32'sd0;
    assign bus.core_valid_o = c_vo;

    // Sink ready: either a fixed level or a random bit.
    logic ready_val  = 1'b1;
    logic rand_ready = 1'b0;
    logic rnd_bit    = 1'b1;
    assign bus.m_ready = rand_ready ? rnd_bit : ready_val;
    initial forever begin
        @(posedge clk);
        #1;
        rnd_bit = ($urandom_range(0, 9) < 7);
    end

    // Expected results and output monitor.
    typedef struct {
        int bin;
        int re1;
        int re2;
        bit last;
    } exp_t;
    exp_t exp_q [$];
    int   rise_q [$];
    logic mv_prev = 1'b0;
    int   run_len = 0;

    always @(negedge clk) begin
        exp_t e;
        if (!arstn) begin
            mv_prev = 1'b0;
            run_len = 0;
        end else begin
            if (bus.m_valid && !mv_prev) rise_q.push_back(cyc);
            mv_prev = bus.m_valid;
            if (!bus.m_valid) chk("m_last_idle", bus.m_last, 0);
            if (bus.core_valid) begin
                run_len++;
            end else if (run_len != 0) begin
                chk("burst_len", run_len, FL);
                run_len = 0;
            end
            if (bus.m_valid && bus.m_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("m_bin", bus.m_bin, e.bin);
                    chk("m_re1", bus.m_re1, e.re1);
                    chk("m_im1", bus.m_im1, 0);
                    chk("m_re2", bus.m_re2, e.re2);
                    chk("m_im2", bus.m_im2, 0);
                    chk("m_last", bus.m_last, e.last);
                end
            end
        end
    end

    // Table of hand-computed frames: {x1, x2, gap before sample 1, expected re1/re2 per bin}.
    typedef struct packed {
        logic [2:0][15:0] x1;
        logic [2:0][15:0] x2;
        logic [2:0][3:0]  gap;
        logic [2:0][31:0] re1;
        logic [2:0][31:0] re2;
    } vec_t;
    vec_t tbl [4];

    function automatic vec_t mk(input int x1a, x1b, x1c, x2a, x2b, x2c, g1,
                                input int r1a, r1b, r1c, r2a, r2b, r2c);
        vec_t v;
        v.x1[0] = 16'(x1a); v.x1[1] = 16'(x1b); v.x1[2] = 16'(x1c);
        v.x2[0] = 16'(x2a); v.x2[1] = 16'(x2b); v.x2[2] = 16'(x2c);
        v.gap    = '0;
        v.gap[1] = 4'(g1);
        v.re1[0] = 32'(r1a); v.re1[1] = 32'(r1b); v.re1[2] = 32'(r1c);
        v.re2[0] = 32'(r2a); v.re2[1] = 32'(r2b); v.re2[2] = 32'(r2c);
        return v;
    endfunction

    task automatic push_sample(input int a, input int b, input int gap, output int acc_cyc);
        int   t;
        bit   done;
        logic rdy;
        bus.s_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        bus.s_valid = 1'b1;
        bus.s_x1    = 16'(a);
        bus.s_x2    = 16'(b);
        t = 0;
        done = 1'b0;
        acc_cyc = -1;
        while (!done) begin
            rdy = bus.s_ready;
            @(posedge clk);
            #1;
            if (rdy) begin
                done = 1'b1;
                acc_cyc = cyc;
            end else begin
                t++;
                if (t > 1000) begin
                    chk("s_ready_timeout", 0, 1);
                    done = 1'b1;
                end
            end
        end
        bus.s_valid = 1'b0;
    endtask

    task automatic send_frame(input int a [FL], input int b [FL], input int g [FL], output int last_cyc);
        int c;
        for (int j = 0; j < FL; j++) begin
            push_sample(a[j], b[j], g[j], c);
            last_cyc = c;
        end
    endtask

    task automatic send_row(input int i, output int last_cyc);
        int a [FL];
        int b [FL];
        int g [FL];
        for (int j = 0; j < FL; j++) begin
            a[j] = int'($signed(tbl[i].x1[j]));
            b[j] = int'($signed(tbl[i].x2[j]));
            g[j] = int'(tbl[i].gap[j]);
        end
        send_frame(a, b, g, last_cyc);
    endtask

    task automatic exp_row(input int i);
        exp_t e;
        for (int k = 0; k < NB; k++) begin
            e.bin  = k;
            e.re1  = int'($signed(tbl[i].re1[k]));
            e.re2  = int'($signed(tbl[i].re2[k]));
            e.last = (k == NB - 1);
            exp_q.push_back(e);
        end
    endtask

    // Reference: each bin is the dot product of the frame with that bin's twiddle row.
    task automatic exp_model(input int a [FL], input int b [FL]);
        exp_t e;
        for (int k = 0; k < NB; k++) begin
            e.bin = k;
            e.re1 = 0;
            e.re2 = 0;
            for (int n = 0; n < FL; n++) begin
                e.re1 += W_RE[k][n] * a[n];
                e.re2 += W_RE[k][n] * b[n];
            end
            e.last = (k == NB - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 3000) begin
            @(posedge clk);
            t++;
        end
        #1;
        chk("drain_pending", exp_q.size(), 0);
    endtask

    task automatic wait_mvalid();
        int t = 0;
        while (!bus.m_valid && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("m_valid_timeout", bus.m_valid, 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int p, q, rel;
        int a [FL];
        int b [FL];
        int g [FL];
        logic signed [15:0] r;

        tbl[0] = mk(1, 2, 3, 4, 5, 6, 0, 6, -1, -1, 15, -1, -1);
        tbl[1] = mk(1, 2, 3, 4, 5, 6, 2, 6, -1, -1, 15, -1, -1);
        tbl[2] = mk(-2, 0, 2, 7, -7, 1, 0, 0, -2, -2, 1, 14, -8);
        tbl[3] = mk(-32768, -32768, -32768, -32768, -32768, -32768, 0,
                    -98304, 0, 0, -98304, 0, 0);

        bus.s_valid = 1'b0;
        bus.s_x1    = 16'sd0;
        bus.s_x2    = 16'sd0;

        // Reset values, sampled while reset is held.
        #2 arstn = 1'b0;
        #1;
        chk("rst_s_ready", bus.s_ready, 1);
        chk("rst_busy", bus.busy, 0);
        chk("rst_core_valid", bus.core_valid, 0);
        chk("rst_m_valid", bus.m_valid, 0);
        chk("rst_m_last", bus.m_last, 0);
        chk("rst_m_bin", bus.m_bin, 0);
        chk("rst_m_re1", bus.m_re1, 0);
        chk("rst_m_im2", bus.m_im2, 0);
        repeat (3) @(posedge clk);
        #1 arstn = 1'b1;
        @(posedge clk);
        #1;

        // Table frames with m_ready high: results, latency and bin spacing.
        for (int i = 0; i < 4; i++) begin
            rise_q.delete();
            exp_row(i);
            send_row(i, p);
            chk("busy_after_fill", bus.busy, 1);
            drain();
            chk("rise_count", rise_q.size(), NB);
            if (rise_q.size() == NB) begin
                chk("first_latency", rise_q[0] - p, FL + 1);
                chk("bin_spacing_01", rise_q[1] - rise_q[0], FL + 2);
                chk("bin_spacing_12", rise_q[2] - rise_q[1], FL + 2);
            end
        end

        // Output stall on bin 1.
        ready_val = 1'b0;
        rise_q.delete();
        exp_row(0);
        send_row(0, p);
        wait_mvalid();
        ready_val = 1'b1;
        @(posedge clk);
        #1;
        ready_val = 1'b0;
        wait_mvalid();
        for (int s = 0; s < 10; s++) begin
            chk("stall_m_valid", bus.m_valid, 1);
            chk("stall_m_bin", bus.m_bin, 1);
            chk("stall_m_re1", bus.m_re1, int'($signed(tbl[0].re1[1])));
            chk("stall_m_re2", bus.m_re2, int'($signed(tbl[0].re2[1])));
            chk("stall_core_valid", bus.core_valid, 0);
            chk("stall_s_ready", bus.s_ready, 0);
            @(posedge clk);
            #1;
        end
        ready_val = 1'b1;
        rel = cyc;
        drain();
        chk("stall_rise_count", rise_q.size(), NB);
        if (rise_q.size() == NB) chk("release_to_bin2", rise_q[NB-1] - rel, FL + 2);

        // Back-to-back frames A then B, streamed without pause.
        exp_row(0);
        exp_row(2);
        send_row(0, p);
        chk("b2b_s_ready_low", bus.s_ready, 0);
        a[0] = -2; a[1] = 0; a[2] = 2;
        b[0] = 7;  b[1] = -7; b[2] = 1;
        g[0] = 0;  g[1] = 0;  g[2] = 0;
        push_sample(a[0], b[0], 0, q);
        chk("b2b_next_fill", q - p, NB * (FL + 2) + 1);
        push_sample(a[1], b[1], 0, q);
        push_sample(a[2], b[2], 0, q);
        drain();

        // Reset in the middle of RUN discards the frame; the next frame is processed normally.
        send_row(0, p);
        @(posedge clk);
        #1;
        chk("mid_run_core_valid", bus.core_valid, 1);
        arstn = 1'b0;
        #1;
        chk("mrst_m_valid", bus.m_valid, 0);
        chk("mrst_core_valid", bus.core_valid, 0);
        chk("mrst_s_ready", bus.s_ready, 1);
        chk("mrst_busy", bus.busy, 0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 arstn = 1'b1;
        @(posedge clk);
        #1;
        exp_row(0);
        send_row(0, p);
        drain();

        // Randomized frames with random bubbles and random sink back-pressure.
        rand_ready = 1'b1;
        for (int f = 0; f < 10; f++) begin
            for (int j = 0; j < FL; j++) begin
                r = 16'($urandom);
                a[j] = int'(r);
                r = 16'($urandom);
                b[j] = int'(r);
                g[j] = $urandom_range(0, 2);
            end
            exp_model(a, b);
            send_frame(a, b, g, p);
        end
        drain();
        rand_ready = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
